// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: packet-aware round-robin arbiter driving one FIFO write port
module fifo_wr_arbiter #(
   parameter int unsigned PORTS     = 4,
   parameter int unsigned WIDTH     = 512,
   parameter int unsigned MAX_BURST = 16,
   localparam int unsigned IW = $clog2(PORTS),
   localparam int unsigned CW = $clog2(MAX_BURST + 1)
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic [PORTS-1:0]       s_valid_i,
   input  logic [PORTS*WIDTH-1:0] s_data_i,
   input  logic [PORTS-1:0]       s_last_i,
   output logic [PORTS-1:0]       s_ready_o,
   output logic                   fifo_wr_en_o,
   output logic [WIDTH-1:0]       fifo_data_in_o,
   input  logic                   fifo_full_i,
   output logic                   grant_valid_o,
   output logic [IW-1:0]          grant_id_o,
   output logic [CW-1:0]          beat_cnt_o
);
   typedef enum logic {IDLE, BUSY} state_t;
   state_t        state_q, state_d;
   logic [IW-1:0] grant_id_q, grant_id_d, last_id_q, last_id_d, sel, idx;
   logic [CW-1:0] beat_cnt_q, beat_cnt_d;
   logic          busy, beat, done;
   assign busy           = state_q == BUSY;
   assign beat           = busy & s_valid_i[grant_id_q] & ~fifo_full_i;
   assign done           = beat & (s_last_i[grant_id_q] | beat_cnt_q == CW'(MAX_BURST - 1));
   assign s_ready_o      = (busy & ~fifo_full_i) ? PORTS'(1) << grant_id_q : '0;
   assign fifo_wr_en_o   = beat;
   assign fifo_data_in_o = s_data_i[grant_id_q*WIDTH +: WIDTH];
   assign grant_valid_o  = busy;
   assign grant_id_o     = grant_id_q;
   assign beat_cnt_o     = beat_cnt_q;
   // first valid requester searching upward from the port after the last grant
   always_comb begin
      sel = '0;
      idx = '0;
      for (int k = PORTS - 1; k >= 0; k--) begin
         idx = IW'((int'(last_id_q) + 1 + k) % PORTS);
         sel = s_valid_i[idx] ? idx : sel;
      end
   end
   // next-state: grant from IDLE, count beats and release on last beat or burst cut
   always_comb begin
      state_d    = state_q;
      grant_id_d = grant_id_q;
      last_id_d  = last_id_q;
      beat_cnt_d = beat_cnt_q;
      if (!busy && |s_valid_i) begin
         state_d    = BUSY;
         grant_id_d = sel;
         beat_cnt_d = '0;
      end
      if (beat) beat_cnt_d = (beat_cnt_q == CW'(MAX_BURST)) ? beat_cnt_q : beat_cnt_q + 1'b1;
      if (done) begin
         state_d    = IDLE;
         last_id_d  = grant_id_q;
         beat_cnt_d = '0;
      end
   end
   // state registers; reset points the RR pointer at the last port so port 0 wins first
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q    <= IDLE;
         grant_id_q <= '0;
         last_id_q  <= IW'(PORTS - 1);
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         grant_id_q <= grant_id_d;
         last_id_q  <= last_id_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed checks of grant order, packets, burst cut, full and reset
module tb_fifo_wr_arbiter;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  s_valid = '0, s_last = '0, s_ready;
   logic [63:0] s_data = '0;
   logic        fifo_full = 1'b0, wr_en, gv;
   logic [15:0] data_in;
   logic [1:0]  gid;
   logic [4:0]  bcnt;
   logic        rst_n_b = 1'b0;
   logic [2:0]  v_b = '0, l_b = 3'b111, r_b;
   logic [23:0] d_b = 24'h302010;
   logic        wr_b, gv_b;
   logic [7:0]  di_b;
   logic [1:0]  gid_b;
   logic [2:0]  bc_b;
   int checks = 0, errors = 0;
   always #5 clk = ~clk;
   fifo_wr_arbiter #(.PORTS(4), .WIDTH(16), .MAX_BURST(16)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .s_valid_i(s_valid), .s_data_i(s_data), .s_last_i(s_last),
      .s_ready_o(s_ready), .fifo_wr_en_o(wr_en), .fifo_data_in_o(data_in), .fifo_full_i(fifo_full),
      .grant_valid_o(gv), .grant_id_o(gid), .beat_cnt_o(bcnt));
   fifo_wr_arbiter #(.PORTS(3), .WIDTH(8), .MAX_BURST(4)) dut_b (
      .clk_i(clk), .rst_n_i(rst_n_b), .s_valid_i(v_b), .s_data_i(d_b), .s_last_i(l_b),
      .s_ready_o(r_b), .fifo_wr_en_o(wr_b), .fifo_data_in_o(di_b), .fifo_full_i(1'b0),
      .grant_valid_o(gv_b), .grant_id_o(gid_b), .beat_cnt_o(bc_b));
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic idle_cyc();
      #1;
      chk("idle_gv", gv, 0);
      chk("idle_wr", wr_en, 0);
      chk("idle_rdy", s_ready, 0);
      chk("idle_cnt", bcnt, 0);
      step();
   endtask
   task automatic beats(input int p, input int first, input int n, input int total, input int cnt0);
      for (int b = first; b < first + n; b++) begin
         s_data[p*16 +: 16] = {p[3:0], b[11:0]};
         s_last[p] = (b == total - 1);
         #1;
         chk("gv", gv, 1);
         chk("gid", gid, p);
         chk("wr", wr_en, 1);
         chk("data", data_in, {p[3:0], b[11:0]});
         chk("rdy", s_ready, 4'b1 << p);
         chk("cnt", bcnt, cnt0 + b - first);
         step();
      end
   endtask
   initial begin
      s_valid = 4'b1111;
      s_last  = 4'b1111;
      step();
      step();
      chk("rst_gv", gv, 0);
      chk("rst_gid", gid, 0);
      chk("rst_cnt", bcnt, 0);
      chk("rst_rdy", s_ready, 0);
      chk("rst_wr", wr_en, 0);
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         idle_cyc();
         beats(k % 4, 0, 1, 1, 0);
      end
      s_valid = 4'b0101;
      idle_cyc();
      beats(2, 0, 5, 5, 0);
      s_valid[2] = 1'b0;
      idle_cyc();
      beats(0, 0, 1, 1, 0);
      s_valid = 4'b1010;
      idle_cyc();
      beats(1, 0, 16, 20, 0);
      idle_cyc();
      beats(3, 0, 1, 1, 0);
      s_valid[3] = 1'b0;
      idle_cyc();
      beats(1, 16, 4, 20, 0);
      s_valid = 4'b0100;
      idle_cyc();
      beats(2, 0, 2, 6, 0);
      fifo_full = 1'b1;
      s_data[32 +: 16] = 16'h2002;
      s_last[2] = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("full_wr", wr_en, 0);
         chk("full_rdy", s_ready, 0);
         chk("full_cnt", bcnt, 2);
         chk("full_gv", gv, 1);
         step();
      end
      fifo_full = 1'b0;
      beats(2, 2, 4, 6, 2);
      s_valid = 4'b1000;
      idle_cyc();
      beats(3, 0, 3, 10, 0);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      #1;
      chk("mrst_gv", gv, 0);
      chk("mrst_rdy", s_ready, 0);
      chk("mrst_wr", wr_en, 0);
      chk("mrst_gid", gid, 0);
      s_valid = 4'b1001;
      idle_cyc();
      beats(0, 0, 1, 1, 0);
      s_valid = 4'b1000;
      idle_cyc();
      beats(3, 0, 1, 1, 0);
      s_valid = '0;
      rst_n_b = 1'b1;
      v_b = 3'b100;
      for (int k = 0; k < 2; k++) begin
         #1;
         chk("b_idle_gv", gv_b, 0);
         step();
         chk("b_gid2", gid_b, 2);
         chk("b_wr2", wr_b, 1);
         chk("b_data2", di_b, 8'h30);
         chk("b_rdy2", r_b, 3'b100);
         step();
      end
      v_b = 3'b101;
      step();
      chk("b_wrap_gid", gid_b, 0);
      chk("b_wrap_data", di_b, 8'h10);
      chk("b_wrap_rdy", r_b, 3'b001);
      step();
      step();
      chk("b_next_gid", gid_b, 2);
      chk("b_next_wr", wr_b, 1);
      step();
      v_b = '0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
